// File: rtl/alarm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alarm_sequencer
// Purpose  : Alarm clock ring/snooze sequencer with missed-alarm flag and an
//            optional hourly chime (enabled by defining HOURLY_CHIME_EN).
// Revision : 1.0 - initial release
// ============================================================================
module alarm_sequencer #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic [23:0] cur_time,
  input  logic [23:0] alarm_time,
  input  logic        alarm_on,
  input  logic        snooze_req,
  input  logic        stop_req,
  output logic        beep_en,
  output logic        tone_sel,
  output logic [1:0]  state,
  output logic [2:0]  snooze_cnt,
  output logic        alarm_missed
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RING   = 2'b01,
    ST_SNOOZE = 2'b10,
    ST_CHIME  = 2'b11
  } state_t;

  localparam logic [7:0] c_ring_last   = 8'(RING_SECS - 1);
  localparam logic [7:0] c_ring_half   = 8'(RING_SECS / 2);
  localparam logic [9:0] c_snooze_load = 10'(SNOOZE_SECS);
  localparam logic [2:0] c_max_snooze  = 3'(MAX_SNOOZE);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_sec_cnt, w_sec_cnt_nxt;
  logic [9:0] r_wait_cnt, w_wait_cnt_nxt;
  logic [2:0] r_snooze_cnt, w_snooze_cnt_nxt;
  logic       r_beep, w_beep_nxt;
  logic       r_tone, w_tone_nxt;
  logic       r_missed, w_missed_nxt;
  logic       w_match;
  logic [7:0] w_sec_inc;

`ifdef HOURLY_CHIME_EN
  logic       r_chime_cnt, w_chime_cnt_nxt;
  logic       w_top_of_hour;

  assign w_top_of_hour = tick_1hz && (cur_time[15:0] == 16'h0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_chime_cnt <= 1'b0;
    else     r_chime_cnt <= w_chime_cnt_nxt;
  end
`endif

  assign w_match   = tick_1hz && alarm_on && (cur_time == alarm_time);
  assign w_sec_inc = r_sec_cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sec_cnt    <= '0;
      r_wait_cnt   <= '0;
      r_snooze_cnt <= '0;
      r_beep       <= 1'b0;
      r_tone       <= 1'b0;
      r_missed     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sec_cnt    <= w_sec_cnt_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_snooze_cnt <= w_snooze_cnt_nxt;
      r_beep       <= w_beep_nxt;
      r_tone       <= w_tone_nxt;
      r_missed     <= w_missed_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_sec_cnt_nxt    = r_sec_cnt;
    w_wait_cnt_nxt   = r_wait_cnt;
    w_snooze_cnt_nxt = r_snooze_cnt;
    w_beep_nxt       = r_beep;
    w_tone_nxt       = r_tone;
    w_missed_nxt     = r_missed;
`ifdef HOURLY_CHIME_EN
    w_chime_cnt_nxt  = r_chime_cnt;
`endif

    if (r_state == ST_IDLE) begin
      // Disarm only clears the event's snooze count; chime entry stays open.
      if (!alarm_on) w_snooze_cnt_nxt = '0;
      if (alarm_on && stop_req) begin
        w_missed_nxt = 1'b0;
      end else if (w_match) begin
        w_state_nxt      = ST_RING;
        w_sec_cnt_nxt    = '0;
        w_beep_nxt       = 1'b1;
        w_tone_nxt       = 1'b0;
        w_snooze_cnt_nxt = '0;
      end
`ifdef HOURLY_CHIME_EN
      else if (w_top_of_hour) begin
        w_state_nxt     = ST_CHIME;
        w_beep_nxt      = 1'b1;
        w_tone_nxt      = 1'b1;
        w_chime_cnt_nxt = 1'b0;
      end
`endif
    end else if (!alarm_on || stop_req) begin
      w_state_nxt      = ST_IDLE;
      w_sec_cnt_nxt    = '0;
      w_wait_cnt_nxt   = '0;
      w_snooze_cnt_nxt = '0;
      w_beep_nxt       = 1'b0;
      w_tone_nxt       = 1'b0;
`ifdef HOURLY_CHIME_EN
      w_chime_cnt_nxt  = 1'b0;
`endif
      if (alarm_on) w_missed_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_RING: begin
          if (snooze_req && (r_snooze_cnt < c_max_snooze)) begin
            w_state_nxt      = ST_SNOOZE;
            w_snooze_cnt_nxt = r_snooze_cnt + 3'd1;
            w_wait_cnt_nxt   = c_snooze_load;
            w_sec_cnt_nxt    = '0;
            w_beep_nxt       = 1'b0;
            w_tone_nxt       = 1'b0;
          end else if (tick_1hz) begin
            if (r_sec_cnt == c_ring_last) begin
              w_state_nxt   = ST_IDLE;
              w_sec_cnt_nxt = '0;
              w_beep_nxt    = 1'b0;
              w_tone_nxt    = 1'b0;
              w_missed_nxt  = 1'b1;
            end else begin
              w_sec_cnt_nxt = w_sec_inc;
              w_beep_nxt    = ~r_beep;
              w_tone_nxt    = (w_sec_inc >= c_ring_half);
            end
          end
        end
        ST_SNOOZE: begin
          if (tick_1hz) begin
            if (r_wait_cnt == 10'd1) begin
              w_state_nxt    = ST_RING;
              w_wait_cnt_nxt = '0;
              w_sec_cnt_nxt  = '0;
              w_beep_nxt     = 1'b1;
              w_tone_nxt     = 1'b0;
            end else begin
              w_wait_cnt_nxt = r_wait_cnt - 10'd1;
            end
          end
        end
`ifdef HOURLY_CHIME_EN
        ST_CHIME: begin
          // Second tick after entry ends the chime.
          if (tick_1hz) begin
            if (r_chime_cnt) begin
              w_state_nxt     = ST_IDLE;
              w_beep_nxt      = 1'b0;
              w_tone_nxt      = 1'b0;
              w_chime_cnt_nxt = 1'b0;
            end else begin
              w_chime_cnt_nxt = 1'b1;
            end
          end
        end
`endif
        default: begin
          w_state_nxt = ST_IDLE;
          w_beep_nxt  = 1'b0;
          w_tone_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign state        = r_state;
  assign beep_en      = r_beep;
  assign tone_sel     = r_tone;
  assign snooze_cnt   = r_snooze_cnt;
  assign alarm_missed = r_missed;

endmodule
`default_nettype wire
